// File: rtl/arb_rr_8.sv
// -----------------------------------------------------------------------------
// arb_rr_8 : eight-way round-robin arbiter with hold limit and inter-grant gap.
//
// A requester wins in IDLE by rotated priority, starting at the slot just after
// the previous owner. It keeps the grant until it releases (done_i), drops its
// request, or reaches MAX_HOLD cycles. One GAP cycle always follows a grant.
//
// All outputs are registered from the current state. They therefore trail the
// FSM by one cycle, and no input has a combinational path to an output.
//
// Ports
//   clk_i        in   1  clock, rising edge
//   reset_n_i    in   1  asynchronous active-low reset
//   enable_i     in   1  allows new grants (sampled in IDLE only)
//   req_i        in   8  request vector, bit k = requester k
//   done_i       in   1  owner release strobe (sampled in GRANT only)
//   grant_o      out  8  one-hot grant, zero when nobody owns the resource
//   grant_idx_o  out  3  index of the current or most recent owner
//   busy_o       out  1  resource is granted
//   timeout_o    out  1  one-cycle pulse when a grant is ended by the hold limit
// -----------------------------------------------------------------------------
module arb_rr_8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [2:0]       grant_idx_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int IDX_W = 3;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  // Compare value for the last permitted GRANT cycle; the guard keeps the
  // constant legal when the limit is disabled.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  // Requests rotated so that bit 0 is the slot at ptr_q. The 3-bit sum wraps
  // naturally modulo 8.
  logic [N_REQ-1:0]   rot_req;
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot_req[gi] = req_i[ptr_q + IDX_W'(gi)];
  end

  // Lowest set bit of the rotated vector is the winner.
  logic [IDX_W-1:0]   sel_off;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  always_comb begin
    sel_off   = '0;
    sel_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        sel_off   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
    sel_idx = ptr_q + sel_off;
  end

  logic rel_hit;
  logic limit_hit;
  assign rel_hit   = done_i | ~req_i[idx_q];
  assign limit_hit = HOLD_EN && (hold_q == HOLD_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    grant_d   = '0;
    gidx_d    = idx_q;
    busy_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && sel_valid) begin
          idx_d   = sel_idx;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_d[idx_q] = 1'b1;
        busy_d         = 1'b1;
        hold_d         = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        if (rel_hit || limit_hit) begin
          state_d   = ST_GAP;
          ptr_d     = idx_q + 1'b1;
          // A release in the same cycle as the limit counts as a normal release.
          timeout_d = limit_hit & ~rel_hit;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = gidx_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_arb_rr_8.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_8 : directed, table-driven bench for arb_rr_8 (MAX_HOLD = 16).
// Each table row gives the inputs presented before a rising edge and the
// outputs expected just after it. Hand-written sequences cover the hold
// limit and the asynchronous reset.
// -----------------------------------------------------------------------------
module tb_arb_rr_8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  arb_rr_8 #(.N_REQ(8), .MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .enable_i    (enable),
    .req_i       (req),
    .done_i      (done),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic en, input logic [7:0] r, input logic d,
                     input logic [7:0] g, input logic [2:0] idx,
                     input logic b, input logic t);
    vec_t v;
    v.en = en; v.req = r; v.done = d; v.g = g; v.idx = idx; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  // Present inputs, then sample the outputs 1 time unit after the next edge.
  task automatic step(input logic en, input logic [7:0] r, input logic d);
    enable = en;
    req    = r;
    done   = d;
    @(posedge clk);
    #1;
    $display("t=%0t en=%b req=%h done=%b -> grant=%h idx=%0d busy=%b to=%b",
             $time, en, r, d, grant, grant_idx, busy, timeout);
  endtask

  initial begin
    // ---------------- table construction ----------------
    // Single requester 0: two edges to grant, release on done.
    add(1, 8'h01, 0, 8'h00, 0, 0, 0);
    add(1, 8'h01, 0, 8'h01, 0, 1, 0);
    add(1, 8'h01, 1, 8'h01, 0, 1, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    // All requesting, ptr = 1: rotation 02,04,...,80,01,02 with 2 idle cycles.
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
    for (int n = 0; n < 9; n++) begin
      logic [2:0] k;
      logic [7:0] oh;
      k  = 3'((1 + n) % 8);
      oh = 8'h01 << k;
      add(1, 8'hFF, 1, oh,    k, 1, 0);
      add(1, 8'hFF, 0, 8'h00, k, 0, 0);
      add(1, 8'hFF, 0, 8'h00, k, 0, 0);
    end
    // Owner 2 is in GRANT; dropping its request releases it (ptr = 3).
    add(1, 8'h00, 0, 8'h04, 2, 1, 0);
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);
    // enable low: no grant.
    for (int n = 0; n < 4; n++) add(0, 8'h10, 0, 8'h00, 2, 0, 0);
    // Enable for one IDLE cycle, then drop it: grant to 4 runs until done.
    add(1, 8'h10, 0, 8'h00, 2, 0, 0);
    for (int n = 0; n < 3; n++) add(0, 8'h10, 0, 8'h10, 4, 1, 0);
    add(0, 8'h10, 1, 8'h10, 4, 1, 0);
    add(0, 8'h10, 0, 8'h00, 4, 0, 0);
    add(0, 8'h10, 0, 8'h00, 4, 0, 0);
    // ptr = 5: owner 5 drops request while 2 waits; wrap scan picks 2.
    add(1, 8'h24, 0, 8'h00, 4, 0, 0);
    add(1, 8'h24, 0, 8'h20, 5, 1, 0);
    add(1, 8'h04, 0, 8'h20, 5, 1, 0);
    add(1, 8'h04, 0, 8'h00, 5, 0, 0);
    add(1, 8'h04, 0, 8'h00, 5, 0, 0);
    add(1, 8'h04, 0, 8'h04, 2, 1, 0);
    add(1, 8'h04, 1, 8'h04, 2, 1, 0);
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);
    // ptr = 3, requests 7 and 2: scan 3..7 picks 7, ptr becomes 0.
    add(1, 8'h84, 0, 8'h00, 2, 0, 0);
    add(1, 8'h84, 1, 8'h80, 7, 1, 0);
    add(1, 8'h00, 0, 8'h00, 7, 0, 0);
    add(1, 8'h00, 0, 8'h00, 7, 0, 0);

    // ---------------- reset ----------------
    reset_n = 1'b0;
    enable  = 1'b0;
    req     = 8'h00;
    done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",   grant,          8'h00);
    chk("rst_idx",     8'(grant_idx),  8'h00);
    chk("rst_busy",    8'(busy),       8'h00);
    chk("rst_timeout", 8'(timeout),    8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req, vecs[i].done);
      chk($sformatf("v%0d_grant", i),   grant,         vecs[i].g);
      chk($sformatf("v%0d_idx", i),     8'(grant_idx), 8'(vecs[i].idx));
      chk($sformatf("v%0d_busy", i),    8'(busy),      8'(vecs[i].busy));
      chk($sformatf("v%0d_timeout", i), 8'(timeout),   8'(vecs[i].to));
    end

    // ---------------- hold limit (ptr = 0) ----------------
    step(1, 8'h08, 0);
    chk("to_start_grant", grant, 8'h00);
    for (int c = 1; c <= 16; c++) begin
      step(1, 8'h08, 0);
      chk($sformatf("to_c%0d_grant", c), grant, 8'h08);
      chk($sformatf("to_c%0d_timeout", c), 8'(timeout), (c == 16) ? 8'h01 : 8'h00);
    end
    step(1, 8'h08, 0);
    chk("to_gap_grant",   grant,        8'h00);
    chk("to_gap_timeout", 8'(timeout),  8'h00);
    chk("to_gap_idx",     8'(grant_idx), 8'h03);
    step(1, 8'h08, 0);
    chk("to_idle_grant",  grant,        8'h00);
    // Regranted to 3; done lands on the limit cycle, so no timeout pulse.
    for (int c = 1; c <= 16; c++) begin
      step(1, 8'h08, (c == 16));
      chk($sformatf("rg_c%0d_grant", c), grant, 8'h08);
      chk($sformatf("rg_c%0d_timeout", c), 8'(timeout), 8'h00);
    end
    step(1, 8'h00, 0);
    chk("rg_gap_grant", grant, 8'h00);
    step(1, 8'h00, 0);
    chk("rg_idle_busy", 8'(busy), 8'h00);

    // ---------------- asynchronous reset mid-grant (ptr = 4) ----------------
    step(1, 8'h81, 0);
    step(1, 8'h81, 0);
    chk("pre_rst_grant", grant,         8'h80);
    chk("pre_rst_idx",   8'(grant_idx), 8'h07);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", grant,         8'h00);
    chk("async_busy",  8'(busy),      8'h00);
    chk("async_idx",   8'(grant_idx), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 8'h81, 0);
    chk("post_rst_wait", grant, 8'h00);
    step(1, 8'h81, 0);
    chk("post_rst_grant", grant,         8'h01);
    chk("post_rst_idx",   8'(grant_idx), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
